// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction field layout, default vectors.
package cpu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } fetch_state_t;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 4;

  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;
  localparam int unsigned RS_HI  = 25;
  localparam int unsigned RS_LO  = 21;
  localparam int unsigned RT_HI  = 20;
  localparam int unsigned RT_LO  = 16;
  localparam int unsigned RD_HI  = 15;
  localparam int unsigned RD_LO  = 11;
  localparam int unsigned IMM_HI = 15;
  localparam int unsigned IMM_LO = 0;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_00FF;

endpackage : cpu_pkg

// File: rtl/instr_fields.sv
// Combinational slicer from an instruction word to its decode fields.
module instr_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0]       i_ir,
  output logic [OPC_HI-OPC_LO:0]   o_opcode,
  output logic [RS_HI-RS_LO:0]     o_rs,
  output logic [RT_HI-RT_LO:0]     o_rt,
  output logic [RD_HI-RD_LO:0]     o_rd,
  output logic [IMM_HI-IMM_LO:0]   o_imm
);

  assign o_opcode = i_ir[OPC_HI:OPC_LO];
  assign o_rs     = i_ir[RS_HI:RS_LO];
  assign o_rt     = i_ir[RT_HI:RT_LO];
  assign o_rd     = i_ir[RD_HI:RD_LO];
  assign o_imm    = i_ir[IMM_HI:IMM_LO];

endmodule : instr_fields

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns PC, IR and EPC, issues fixed-latency memory reads,
// applies redirects and exception vectoring, pulses fetch_done on completion.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      MEM_LATENCY = 1,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  parameter logic [31:0]      EXC_VECTOR  = EXC_VECTOR_DEFAULT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                exception,
  output logic [XLEN-1:0]     mem_addr,
  output logic                mem_rd,
  input  logic [INSTR_W-1:0]  mem_rdata,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic [XLEN-1:0]     epc,
  output logic [INSTR_W-1:0]  ir,
  output logic [5:0]          opcode,
  output logic [4:0]          rs,
  output logic [4:0]          rt,
  output logic [4:0]          rd,
  output logic [15:0]         imm,
  output logic                fetch_done,
  output logic                busy
);

  localparam logic [XLEN-1:0]  EXC_PC   = XLEN'(EXC_VECTOR);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  fetch_state_t     r_state, w_state_nxt;
  logic [XLEN-1:0]  r_pc, w_pc_nxt;
  logic [XLEN-1:0]  r_last_pc, w_last_pc_nxt;
  logic [XLEN-1:0]  r_epc, w_epc_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_fetch_done, w_fetch_done_nxt;
  logic [XLEN-1:0]  w_pc_plus4;
  logic [XLEN-1:0]  w_redirect_aligned;

  assign w_pc_plus4         = r_pc + XLEN'(4);
  assign w_redirect_aligned = redirect_pc & ~XLEN'(3);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and datapath updates; exception outranks everything in any state.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_last_pc_nxt    = r_last_pc;
    w_epc_nxt        = r_epc;
    w_ir_nxt         = r_ir;
    w_cnt_nxt        = r_cnt;
    w_fetch_done_nxt = 1'b0;
    if (exception) begin
      w_epc_nxt   = r_last_pc;
      w_pc_nxt    = EXC_PC;
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            w_pc_nxt = w_redirect_aligned;
          end else if (fetch_req) begin
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = READ;
          end
        end
        READ: begin
          if (r_cnt == CNT_ONE) begin
            w_ir_nxt         = mem_rdata;
            w_last_pc_nxt    = r_pc;
            w_pc_nxt         = w_pc_plus4;
            w_fetch_done_nxt = 1'b1;
            w_state_nxt      = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_last_pc    <= '0;
      r_epc        <= '0;
      r_ir         <= '0;
      r_cnt        <= '0;
      r_fetch_done <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_last_pc    <= w_last_pc_nxt;
      r_epc        <= w_epc_nxt;
      r_ir         <= w_ir_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fetch_done <= w_fetch_done_nxt;
    end
  end

  assign mem_addr   = r_pc;
  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign epc        = r_epc;
  assign ir         = r_ir;
  assign fetch_done = r_fetch_done;
  assign busy       = (r_state == READ);
  assign mem_rd     = (r_state == READ);

  instr_fields u_fields (
    .i_ir     (r_ir),
    .o_opcode (opcode),
    .o_rs     (rs),
    .o_rt     (rt),
    .o_rd     (rd),
    .o_imm    (imm)
  );

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three configurations share one stimulus stream and are
// compared every cycle against a cycle-count based reference model.
module tb_fetch_unit;

  localparam int unsigned N = 3;

  logic        clock = 1'b0;
  logic        reset, fetch_req, redirect_valid, exception;
  logic [31:0] redirect_pc;

  logic [31:0] mem_addr [N];
  logic [31:0] rdata    [N];
  logic [31:0] pc       [N];
  logic [31:0] pc4      [N];
  logic [31:0] epc      [N];
  logic [31:0] ir       [N];
  logic [5:0]  opc      [N];
  logic [4:0]  rs       [N];
  logic [4:0]  rt       [N];
  logic [4:0]  rd       [N];
  logic [15:0] imm      [N];
  logic        mem_rd   [N];
  logic        done     [N];
  logic        busy     [N];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_pc   [N];
  logic [31:0] m_ir   [N];
  logic [31:0] m_epc  [N];
  logic [31:0] m_last [N];
  bit          m_busy [N];
  bit          m_done [N];
  int          m_fin  [N];
  int          edge_n = 0;

  always #5 clock = ~clock;

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    if (a == 32'h4) return 32'h0000_0000;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [31:0] rst_pc_of(input int i);
    return (i == 2) ? 32'hFFFF_FFFC : 32'h0;
  endfunction

  assign rdata[0] = memword(mem_addr[0]);
  assign rdata[1] = memword(mem_addr[1]);
  assign rdata[2] = memword(mem_addr[2]);

  fetch_unit #(.XLEN(32), .MEM_LATENCY(1), .RESET_PC(32'h0)) u0 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exception(exception), .mem_addr(mem_addr[0]), .mem_rd(mem_rd[0]),
    .mem_rdata(rdata[0]), .pc(pc[0]), .pc_plus4(pc4[0]), .epc(epc[0]), .ir(ir[0]),
    .opcode(opc[0]), .rs(rs[0]), .rt(rt[0]), .rd(rd[0]), .imm(imm[0]),
    .fetch_done(done[0]), .busy(busy[0]));

  fetch_unit #(.XLEN(32), .MEM_LATENCY(3), .RESET_PC(32'h0)) u1 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exception(exception), .mem_addr(mem_addr[1]), .mem_rd(mem_rd[1]),
    .mem_rdata(rdata[1]), .pc(pc[1]), .pc_plus4(pc4[1]), .epc(epc[1]), .ir(ir[1]),
    .opcode(opc[1]), .rs(rs[1]), .rt(rt[1]), .rd(rd[1]), .imm(imm[1]),
    .fetch_done(done[1]), .busy(busy[1]));

  fetch_unit #(.XLEN(32), .MEM_LATENCY(2), .RESET_PC(32'hFFFF_FFFC)) u2 (
    .clock(clock), .reset(reset), .fetch_req(fetch_req), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .exception(exception), .mem_addr(mem_addr[2]), .mem_rd(mem_rd[2]),
    .mem_rdata(rdata[2]), .pc(pc[2]), .pc_plus4(pc4[2]), .epc(epc[2]), .ir(ir[2]),
    .opcode(opc[2]), .rs(rs[2]), .rt(rt[2]), .rd(rd[2]), .imm(imm[2]),
    .fetch_done(done[2]), .busy(busy[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One edge of the reference model for instance i, using the currently driven inputs.
  task automatic model_step(input int i);
    m_done[i] = 1'b0;
    if (reset) begin
      m_pc[i] = rst_pc_of(i); m_ir[i] = '0; m_epc[i] = '0; m_last[i] = '0; m_busy[i] = 1'b0;
    end else if (exception) begin
      m_epc[i] = m_last[i]; m_pc[i] = 32'h0000_00FF; m_busy[i] = 1'b0;
    end else if (!m_busy[i]) begin
      if (redirect_valid)  m_pc[i] = {redirect_pc[31:2], 2'b00};
      else if (fetch_req) begin
        m_busy[i] = 1'b1;
        m_fin[i]  = edge_n + lat_of(i);
      end
    end else if (edge_n == m_fin[i]) begin
      m_ir[i]   = memword(m_pc[i]);
      m_last[i] = m_pc[i];
      m_pc[i]   = m_pc[i] + 32'd4;
      m_done[i] = 1'b1;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      check_eq($sformatf("u%0d.pc", i),       pc[i],       m_pc[i]);
      check_eq($sformatf("u%0d.mem_addr", i), mem_addr[i], m_pc[i]);
      check_eq($sformatf("u%0d.pc_plus4", i), pc4[i],      m_pc[i] + 32'd4);
      check_eq($sformatf("u%0d.epc", i),      epc[i],      m_epc[i]);
      check_eq($sformatf("u%0d.ir", i),       ir[i],       m_ir[i]);
      check_eq($sformatf("u%0d.fields", i),   {opc[i], rs[i], rt[i], 16'h0}, {m_ir[i][31:16], 16'h0});
      check_eq($sformatf("u%0d.rd_imm", i),   {11'h0, rd[i], imm[i]}, {11'h0, m_ir[i][15:11], m_ir[i][15:0]});
      check_eq($sformatf("u%0d.done", i),     32'(done[i]),   32'(m_done[i]));
      check_eq($sformatf("u%0d.busy", i),     32'(busy[i]),   32'(m_busy[i]));
      check_eq($sformatf("u%0d.mem_rd", i),   32'(mem_rd[i]), 32'(m_busy[i]));
    end
  endtask

  // Drive inputs at the falling edge, advance the model, clock once, check at next fall.
  task automatic tick(input bit rst, input bit exc, input bit rv, input bit fr, input logic [31:0] rpc);
    reset = rst; exception = exc; redirect_valid = rv; fetch_req = fr; redirect_pc = rpc;
    edge_n++;
    for (int i = 0; i < N; i++) model_step(i);
    @(posedge clock);
    @(negedge clock);
    check_all();
  endtask

  // Single fetch pulse with an extra request during READ; counts u1 read cycles and done pulses.
  task automatic pulse_fetch();
    int rd_cnt, dn_cnt, dn_at;
    rd_cnt = 0; dn_cnt = 0; dn_at = 0;
    for (int t = 1; t <= 5; t++) begin
      tick(1'b0, 1'b0, 1'b0, (t == 1 || t == 3), 32'h0);
      rd_cnt += int'(mem_rd[1]);
      if (done[1]) begin dn_cnt++; dn_at = t; end
    end
    check_eq("u1.read_cycles", 32'(rd_cnt), 32'd3);
    check_eq("u1.done_count",  32'(dn_cnt), 32'd1);
    check_eq("u1.done_edge",   32'(dn_at),  32'd4);
  endtask

  initial begin
    reset = 1'b1; exception = 1'b0; redirect_valid = 1'b0; fetch_req = 1'b0; redirect_pc = '0;
    for (int i = 0; i < N; i++) begin
      m_pc[i] = '0; m_ir[i] = '0; m_epc[i] = '0; m_last[i] = '0;
      m_busy[i] = 1'b0; m_done[i] = 1'b0; m_fin[i] = 0;
    end
    @(negedge clock);

    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("u2.reset_pc", pc[2], 32'hFFFF_FFFC);
    check_eq("u0.reset_busy", 32'(busy[0]), 32'd0);

    // Hold fetch_req: latency 1 back-to-back, latency 2 wrap-around.
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("u0.done_early", 32'(done[0]), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("u0.done_1st", 32'(done[0]), 32'd1);
    check_eq("u0.ir_1st",   ir[0],  32'h8C22_0004);
    check_eq("u0.opcode",   32'(opc[0]), 32'h23);
    check_eq("u0.rs",       32'(rs[0]),  32'd1);
    check_eq("u0.rt",       32'(rt[0]),  32'd2);
    check_eq("u0.imm",      32'(imm[0]), 32'h4);
    check_eq("u0.pc_1st",   pc[0],  32'h4);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("u2.pc_wrap",  pc[2],  32'h0);
    check_eq("u2.pc4_wrap", pc4[2], 32'h4);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("u0.pc_2nd",   pc[0],  32'h8);
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Latency-3 single fetches, then exception in the 2nd READ cycle.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) pulse_fetch();
    check_eq("u1.pc_before_exc", pc[1], 32'hC);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    check_eq("u1.exc_epc",  epc[1], 32'h8);
    check_eq("u1.exc_pc",   pc[1],  32'hFF);
    check_eq("u1.exc_busy", 32'(busy[1]), 32'd0);
    check_eq("u1.exc_done", 32'(done[1]), 32'd0);
    check_eq("u1.exc_ir",   ir[1],  memword(32'h8));

    // Redirect wins over a simultaneous fetch_req.
    tick(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103);
    check_eq("u1.redir_pc",   pc[1], 32'h100);
    check_eq("u1.redir_busy", 32'(busy[1]), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    check_eq("u1.redir_addr", mem_addr[1], 32'h100);
    check_eq("u1.redir_rd",   32'(mem_rd[1]), 32'd1);

    // Reset in the middle of READ.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check_eq("u1.rst_pc",   pc[1], 32'h0);
    check_eq("u1.rst_ir",   ir[1], 32'h0);
    check_eq("u1.rst_busy", 32'(busy[1]), 32'd0);
    check_eq("u1.rst_done", 32'(done[1]), 32'd0);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      tick($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 60, rpc);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage for the multicycle CPU. It owns the PC, the instruction register and the EPC. It issues reads to an instruction memory with configurable read latency and applies branch/jump redirects and exception vectoring. It raises a one-cycle completion pulse to the control unit.

## Interface
Parameters:
- XLEN, 32: PC / address width.
- MEM_LATENCY, 1: cycles from read issue to valid `mem_rdata`; legal range 1..15.
- RESET_PC, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_00FF: PC loaded on exception, truncated to XLEN.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  control unit requests the next instruction; sampled only in IDLE.
- redirect_valid  in  1  load `redirect_pc`; sampled only in IDLE.
- redirect_pc  in  XLEN  branch/jump target; bits [1:0] forced to 0 on load.
- exception  in  1  abort any fetch and vector to EXC_VECTOR; sampled in every state.
- mem_addr  out  XLEN  equals `pc` at all times.
- mem_rd  out  1  high in every READ cycle, low otherwise.
- mem_rdata  in  32  instruction word.
- pc  out  XLEN  address of the next instruction to fetch.
- pc_plus4  out  XLEN  `pc + 4`, modulo 2^XLEN.
- epc  out  XLEN  address of the last fetched instruction at exception time.
- ir  out  32  instruction register.
- opcode/rs/rt/rd/imm  out  6/5/5/5/16  `ir[31:26]`, `ir[25:21]`, `ir[20:16]`, `ir[15:11]`, `ir[15:0]`.
- fetch_done  out  1  one-cycle pulse, coincident with the new `ir`.
- busy  out  1  high while the state is READ.

## Operation
- The state machine has two states: IDLE and READ.
- Internal state:
  - `last_pc`, XLEN bits: address of the most recently completed fetch.
  - `cnt`, 4 bits.
- Reset values: `pc`=RESET_PC, `ir`=0, `epc`=0, `last_pc`=0, `cnt`=0, `fetch_done`=0, state=IDLE, so `busy`=0 and `mem_rd`=0.
- Priority at every edge is reset > exception > redirect_valid > fetch_req.
- IDLE:
  - exception: `epc` <= `last_pc`, `pc` <= EXC_VECTOR; stay in IDLE.
  - else redirect_valid: `pc` <= {redirect_pc[XLEN-1:2], 2'b00}; stay in IDLE; a simultaneous fetch_req is dropped and must be re-asserted.
  - else fetch_req: `cnt` <= MEM_LATENCY; go to READ.
- READ:
  - exception: abort the fetch. `epc` <= `last_pc`, `pc` <= EXC_VECTOR, go to IDLE. `ir` is unchanged and no fetch_done is raised.
  - else if `cnt`==1: `ir` <= `mem_rdata`, `last_pc` <= `pc`, `pc` <= `pc_plus4`, `fetch_done` <= 1; go to IDLE.
  - else: `cnt` <= `cnt` - 1.
  - redirect_valid and fetch_req are ignored in READ. The control unit issues them only when `busy`=0.
- `fetch_done` is cleared on every edge where it is not set.
- Wrap-around: PC = 2^XLEN-4 increments to 0 with no flag.
- Reset mid-READ: the fetch is abandoned and all reset values are applied on that edge.

## Timing
- fetch_req sampled at edge k: READ occupies cycles k..k+MEM_LATENCY-1, and `mem_rd` is high in exactly those cycles.
- `ir`, `pc` and `fetch_done` update at edge k+MEM_LATENCY.
- Back-to-back throughput: with fetch_req held high, a new fetch starts on the edge after fetch_done is seen in IDLE, giving one instruction per MEM_LATENCY+1 cycles.
- `mem_rdata` is sampled only at the final READ edge and must be stable then.
- Exception takes effect in one edge from any state. Redirect takes effect in one edge from IDLE.
- All outputs are registered or are pure decodes of registers. There is no combinational path from any input to any output.

## Structure
- Shared package `cpu_pkg` holds:
  - `fetch_state_t` enum {IDLE, READ};
  - INSTR_W=32;
  - field position constants OPC_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, IMM_HI/LO;
  - the default EXC_VECTOR.
- Natural sub-module `instr_fields`: combinational slicer from `ir` to `opcode`/`rs`/`rt`/`rd`/`imm`. It is reused by the decode logic.
- The FSM, `cnt`, `pc`, `last_pc`, `epc` and `ir` stay inline in `fetch_unit`.

## Test plan
- Reset then hold fetch_req with MEM_LATENCY=1, memory word0=32'h8C22_0004, word1=32'h0000_0000:
  - fetch_done pulses 1 cycle after acceptance;
  - `ir`=32'h8C22_0004, `opcode`=6'h23, `rs`=1, `rt`=2, `imm`=16'h0004, `pc`=4;
  - a second fetch gives `pc`=8.
- MEM_LATENCY=3, single fetch_req pulse:
  - `mem_rd` is high for exactly 3 cycles;
  - fetch_done fires at the 3rd edge after acceptance;
  - fetch_req pulses during READ are ignored.
- In IDLE, redirect_valid=1, redirect_pc=32'h0000_0103 and fetch_req=1 on the same edge:
  - `pc`=32'h0000_0100 and no fetch starts;
  - the next fetch_req reads address 32'h100.
- After a completed fetch at address 8, exception asserted in the 2nd READ cycle of the next fetch (MEM_LATENCY=3):
  - `epc`=8, `pc`=32'hFF, state IDLE;
  - `ir` keeps the old value and no fetch_done.
- RESET_PC=32'hFFFF_FFFC, one fetch: `pc` wraps to 0 and `pc_plus4`=4.
- reset asserted mid-READ: the next edge shows `pc`=RESET_PC, `ir`=0, `busy`=0, `fetch_done`=0.
